// File: rtl/mfcc_pkg.sv
// +-----------------------------------------------------------------+
// | mfcc_pkg : shared constants and state types, MFCC front-end     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package mfcc_pkg;

  localparam int NFFT        = 257;
  localparam int DATA_W      = 32;
  localparam int NUM_FILTERS = 26;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/ps_bank_ram.sv
// +-----------------------------------------------------------------+
// | ps_bank_ram : two-bank simple dual-port RAM, sync read port     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module ps_bank_ram #(
  parameter int DEPTH  = mfcc_pkg::NFFT,
  parameter int DATA_W = mfcc_pkg::DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_wsel,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rsel,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  // No reset on the array or read register so the tools can map it to block RAM.
  logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wsel][i_widx] <= i_wdata;
    end
    r_rdata <= r_mem[i_rsel][i_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/power_spectrum_buffer.sv
// +-----------------------------------------------------------------+
// | power_spectrum_buffer : ping-pong frame buffer, FFT power -> MEL|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module power_spectrum_buffer #(
  parameter int NFFT   = mfcc_pkg::NFFT,
  parameter int DATA_W = mfcc_pkg::DATA_W,
  parameter int ADDR_W = $clog2(NFFT) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps_valid_i,
  input  logic [DATA_W-1:0] ps_data_i,
  output logic              ps_ready_o,
  output logic              mel_start_o,
  input  logic              mel_done_i,
  input  logic [ADDR_W-1:0] prt_power_spectrum_frame,
  output logic [DATA_W-1:0] value_power_spectrum_frame,
  output logic              mel_busy_o
);

  import mfcc_pkg::*;

  localparam int              CNT_W = $clog2(NFFT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NFFT - 1);

  wr_state_t         r_wr_state, w_wr_state_nxt;
  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic [CNT_W-1:0]  r_wr_cnt,   w_wr_cnt_nxt;
  logic              r_wr_sel,   w_wr_sel_nxt;
  logic              r_rd_sel,   w_rd_sel_nxt;
  logic              r_start;
  logic              r_in_range;

  logic              w_xfer;
  logic              w_swap;
  logic              w_in_range;
  logic [CNT_W-1:0]  w_ridx;
  logic [DATA_W-1:0] w_ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= FILL;
      r_rd_state <= IDLE;
      r_wr_cnt   <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_start    <= 1'b0;
      r_in_range <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_start    <= w_swap;
      r_in_range <= w_in_range;
    end
  end

  // A done from MEL lands in IDLE first, so a swap always needs one IDLE edge.
  always_comb begin
    w_xfer         = ps_valid_i && ps_ready_o;
    w_swap         = (r_wr_state == FULL) && (r_rd_state == IDLE);
    w_wr_state_nxt = r_wr_state;
    w_rd_state_nxt = r_rd_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_sel_nxt   = r_wr_sel;
    w_rd_sel_nxt   = r_rd_sel;

    if (w_xfer) begin
      if (r_wr_cnt == C_LAST) begin
        w_wr_cnt_nxt   = '0;
        w_wr_state_nxt = FULL;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
      end
    end

    if (w_swap) begin
      w_wr_state_nxt = FILL;
      w_rd_state_nxt = BUSY;
      w_wr_sel_nxt   = ~r_wr_sel;
      w_rd_sel_nxt   = r_wr_sel;
    end else if ((r_rd_state == BUSY) && mel_done_i) begin
      w_rd_state_nxt = IDLE;
    end
  end

  always_comb begin
    ps_ready_o                 = (r_wr_state == FILL) && rst_n;
    mel_start_o                = r_start;
    mel_busy_o                 = (r_rd_state == BUSY);
    value_power_spectrum_frame = r_in_range ? w_ram_q : '0;
  end

  // Out-of-range addresses read a harmless in-range word; the flag zeroes it.
  assign w_in_range = (prt_power_spectrum_frame < ADDR_W'(NFFT));
  assign w_ridx     = w_in_range ? prt_power_spectrum_frame[CNT_W-1:0] : '0;

  ps_bank_ram #(
    .DEPTH  (NFFT),
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_xfer),
    .i_wsel  (r_wr_sel),
    .i_widx  (r_wr_cnt),
    .i_wdata (ps_data_i),
    .i_rsel  (r_rd_sel),
    .i_ridx  (w_ridx),
    .o_rdata (w_ram_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_power_spectrum_buffer.sv
// +-----------------------------------------------------------------+
// | tb_power_spectrum_buffer : scoreboard bench, frame-queue model  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_power_spectrum_buffer;

  localparam int NFFT   = 257;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ps_valid_i = 1'b0;
  logic [DATA_W-1:0] ps_data_i = '0;
  logic              ps_ready_o;
  logic              mel_start_o;
  logic              mel_done_i = 1'b0;
  logic [ADDR_W-1:0] prt = '0;
  logic [DATA_W-1:0] value;
  logic              mel_busy_o;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] bins_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] cur [NFFT];
  logic              rd_issue = 1'b0;
  logic              rd_issue_d = 1'b0;

  always #5 clk = ~clk;

  power_spectrum_buffer #(
    .NFFT   (NFFT),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .ps_valid_i                 (ps_valid_i),
    .ps_data_i                  (ps_data_i),
    .ps_ready_o                 (ps_ready_o),
    .mel_start_o                (mel_start_o),
    .mel_done_i                 (mel_done_i),
    .prt_power_spectrum_frame   (prt),
    .value_power_spectrum_frame (value),
    .mel_busy_o                 (mel_busy_o)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  // Read-data monitor: one expected word per address issued the previous cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_issue_d <= 1'b0;
    else        rd_issue_d <= rd_issue;

  always @(negedge clk) begin
    if (rd_issue_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected: got data %0d expected no read pending", value);
      end else begin
        check("read_data", value, exp_q.pop_front());
      end
    end
  end

  task automatic produce(input int mode, input int gap, input int first, input int count);
    logic [DATA_W-1:0] v;
    bit   accepted;
    int   budget;
    for (int i = first; i < first + count; i++) begin
      v = (mode == 0) ? DATA_W'(i * 3) : (mode == 1) ? DATA_W'(1000 + i) : $urandom;
      accepted = 1'b0;
      budget   = 0;
      while (!accepted) begin
        @(negedge clk);
        ps_data_i  = v;
        ps_valid_i = ($urandom_range(99) >= gap);
        if (ps_valid_i && ps_ready_o) begin
          accepted = 1'b1;
          bins_q.push_back(v);
        end else if (++budget > 4000) begin
          fail_timeout("producer_ready");
          ps_valid_i = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    ps_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc);
    int lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (mel_start_o === 1'b1) break;
      if (lat >= max_cyc) begin
        fail_timeout("wait_start");
        return;
      end
    end
    check("busy_at_start", mel_busy_o, 1);
    @(negedge clk);
    check("start_pulse_width", mel_start_o, 0);
  endtask

  task automatic load_frame();
    if (bins_q.size() < NFFT) begin
      checks++;
      failures++;
      $display("FAIL load_frame: got %0d stored bins expected %0d", bins_q.size(), NFFT);
      for (int i = 0; i < NFFT; i++) cur[i] = '0;
    end else begin
      for (int i = 0; i < NFFT; i++) cur[i] = bins_q.pop_front();
    end
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    @(negedge clk);
    prt      = a;
    rd_issue = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic end_reads();
    @(negedge clk);
    rd_issue = 1'b0;
    repeat (2) @(negedge clk);
    check("read_drain", exp_q.size(), 0);
  endtask

  task automatic read_frame();
    for (int a = 0; a < NFFT; a++) issue_read(ADDR_W'(a), cur[a]);
    issue_read(ADDR_W'(NFFT + $urandom_range(1023 - NFFT)), '0);
    end_reads();
  endtask

  task automatic pulse_done();
    @(negedge clk);
    mel_done_i = 1'b1;
    @(negedge clk);
    mel_done_i = 1'b0;
  endtask

  task automatic mel_serve(input int frames);
    repeat (frames) begin
      wait_start(5000);
      load_frame();
      read_frame();
      pulse_done();
    end
  endtask

  task automatic async_reset_check(input string tag);
    rd_issue = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_ready"}, ps_ready_o, 0);
    check({tag, "_start"}, mel_start_o, 0);
    check({tag, "_busy"},  mel_busy_o, 0);
    check({tag, "_value"}, value, 0);
    bins_q.delete();
    exp_q.delete();
    ps_valid_i = 1'b0;
    mel_done_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts;
    logic [DATA_W-1:0] v;

    // Reset state
    #3;
    check("rst_ready", ps_ready_o, 0);
    check("rst_start", mel_start_o, 0);
    check("rst_busy",  mel_busy_o, 0);
    check("rst_value", value, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", ps_ready_o, 1);

    // Frame 1: idx*3, no gaps
    produce(0, 0, 0, NFFT);
    check("full_ready_low", ps_ready_o, 0);
    check("full_no_start",  mel_start_o, 0);
    @(negedge clk);
    check("swap_start",  mel_start_o, 1);
    check("swap_ready",  ps_ready_o, 1);
    check("swap_busy",   mel_busy_o, 1);
    @(negedge clk);
    check("start_single", mel_start_o, 0);
    load_frame();
    issue_read(ADDR_W'(5),   32'd15);
    issue_read(ADDR_W'(256), 32'd768);
    issue_read(ADDR_W'(300), 32'd0);
    end_reads();

    // Frame 2 written while MEL reads frame 1
    fork
      produce(1, 0, 0, NFFT);
      read_frame();
    join
    repeat (4) begin
      @(negedge clk);
      check("hold_ready_low", ps_ready_o, 0);
      check("hold_no_start",  mel_start_o, 0);
    end
    @(negedge clk);
    mel_done_i = 1'b1;
    @(negedge clk);
    mel_done_i = 1'b0;
    check("b2b_idle_busy",  mel_busy_o, 0);
    check("b2b_start_early", mel_start_o, 0);
    @(negedge clk);
    check("b2b_start_2cyc", mel_start_o, 1);
    @(negedge clk);
    load_frame();
    issue_read(ADDR_W'(10), 32'd1010);
    end_reads();
    read_frame();
    pulse_done();

    // Random producer gaps, 4 frames
    fork
      repeat (4) produce(2, 50, 0, NFFT);
      mel_serve(4);
    join

    // Done coincident with the last write of the next frame
    produce(2, 0, 0, NFFT);
    wait_start(50);
    load_frame();
    read_frame();
    produce(1, 0, 0, NFFT - 1);
    @(negedge clk);
    check("coinc_ready", ps_ready_o, 1);
    v = $urandom;
    ps_data_i  = v;
    ps_valid_i = 1'b1;
    mel_done_i = 1'b1;
    bins_q.push_back(v);
    @(negedge clk);
    ps_valid_i = 1'b0;
    mel_done_i = 1'b0;
    check("coinc_idle_busy",  mel_busy_o, 0);
    check("coinc_idle_start", mel_start_o, 0);
    check("coinc_full_ready", ps_ready_o, 0);
    @(negedge clk);
    check("coinc_start", mel_start_o, 1);
    check("coinc_busy",  mel_busy_o, 1);
    @(negedge clk);
    load_frame();
    read_frame();
    pulse_done();

    // Done while IDLE changes nothing
    repeat (2) @(negedge clk);
    pulse_done();
    repeat (3) begin
      @(negedge clk);
      check("idle_done_busy",  mel_busy_o, 0);
      check("idle_done_start", mel_start_o, 0);
      check("idle_done_ready", ps_ready_o, 1);
    end

    // Reset mid-frame, then reset while MEL busy
    produce(2, 0, 0, 100);
    async_reset_check("rst_midframe");
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (mel_start_o) starts++;
    end
    check("no_start_after_rst", starts, 0);
    produce(2, 0, 0, NFFT);
    wait_start(50);
    load_frame();
    issue_read(ADDR_W'(0), cur[0]);
    end_reads();
    async_reset_check("rst_busy");
    fork
      produce(2, 30, 0, NFFT);
      mel_serve(1);
    join
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (mel_start_o) starts++;
    end
    check("single_start_after_rst", starts, 0);

    // Golden run: 8 frames, random data and gaps
    fork
      repeat (8) produce(2, $urandom_range(60), 0, NFFT);
      mel_serve(8);
    join
    check("bins_left_over", bins_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/power_spectrum_buffer.md
Name: power_spectrum_buffer

Overview:
Ping-pong frame buffer between the power-spectrum producer (FFT magnitude-squared stage) and the MEL filterbank.
- Write side: accepts a stream of NFFT 32-bit power bins per frame.
- Read side: once a full frame is stored and MEL is idle, swaps banks and pulses a start to MEL. It then answers MEL's bin-address reads with one-cycle registered latency until MEL signals done.
- The producer can fill the next frame while MEL processes the current one.

Parameters:
NFFT, 257, bins per frame (512/2+1)
DATA_W, 32, power bin width
ADDR_W, $clog2(NFFT)+1, MEL read-address width (10 for default)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps_valid_i  input  1  producer bin valid
ps_data_i  input  DATA_W  producer bin value
ps_ready_o  output  1  buffer can accept a bin this cycle
mel_start_o  output  1  one-cycle pulse, frame ready for MEL
mel_done_i  input  1  MEL finished current frame (pulse)
prt_power_spectrum_frame  input  ADDR_W  MEL read address (bin index)
value_power_spectrum_frame  output  DATA_W  bin value, registered
mel_busy_o  output  1  read bank owned by MEL

Behaviour:
- Reset (async, rst_n=0) state:
  - All outputs 0.
  - wr_sel=0, wr_cnt=0, write state FILL, read state IDLE.
  - Any partial frame is discarded and no start is issued.
  - Bank contents are not cleared.
- Write side, states FILL / FULL:
  - ps_ready_o = 1 iff state FILL and rst_n deasserted.
  - A transfer occurs on a cycle with ps_valid_i && ps_ready_o. The bin is written to bank[wr_sel][wr_cnt] and wr_cnt increments.
  - On the transfer with wr_cnt==NFFT-1: wr_cnt wraps to 0 and the state goes to FULL (ready drops next cycle).
  - In FULL, ps_valid_i is ignored and the data must be held by the producer.
- Swap:
  - Condition: write state FULL and read state IDLE, evaluated at a clock edge.
  - At that edge: rd_sel <= wr_sel, wr_sel <= ~wr_sel, write state -> FILL, read state -> BUSY, mel_start_o <= 1 for exactly one cycle.
  - mel_busy_o equals read state BUSY, registered.
- Read side, states IDLE / BUSY:
  - In BUSY, mel_done_i=1 -> IDLE at the next edge.
  - mel_done_i in IDLE is ignored.
  - If mel_done_i arrives in the same cycle the write side reaches FULL, the done is taken first. The swap happens on the following edge, giving exactly one IDLE cycle between frames.
  - A back-to-back start, with the write already FULL when done arrives, has mel_start_o 2 cycles after mel_done_i.
- Read data path:
  - value_power_spectrum_frame <= bank[rd_sel][addr] on every posedge, regardless of state. One-cycle latency: the address presented before edge N gives data valid after edge N.
  - addr >= NFFT returns 0.
  - Before the first swap, reads return bank 0 contents (unspecified after power-up).
- Banks are disjoint, so a write to the wr_sel bank never disturbs reads of the rd_sel bank. No read-during-write hazard exists.
- Reset mid-frame or mid-MEL: immediate return to the reset state. MEL must be reset by the same rst_n.

Decomposition:
- mfcc_pkg holds: NFFT, DATA_W, NUM_FILTERS constants; the wr_state_t {FILL, FULL} and rd_state_t {IDLE, BUSY} enums.
- One sub-module, ps_bank_ram: simple dual-port RAM, 2*NFFT x DATA_W.
  - Write port indexed by {wr_sel, wr_cnt}.
  - Synchronous read port indexed by {rd_sel, addr}.
  - Infers block RAM.
- The out-of-range mux-to-zero sits in the top module, using a registered range flag aligned with the RAM output.

Test Plan:
- Reset, then stream bins 0..256 with value = idx*3, no gaps -> ps_ready_o low from cycle after 257th transfer until swap; mel_start_o single pulse; read addr 5 returns 15 next cycle; addr 256 returns 768; addr 300 returns 0.
- Frame 2 (value = 1000+idx) streamed while MEL busy on frame 1 -> frame-1 reads still return idx*3; after frame 2 full, ps_ready_o stays 0 until mel_done_i; mel_start_o exactly 2 cycles after mel_done_i; addr 10 returns 1010.
- Producer with random ps_valid_i gaps (50%) -> exactly 257 bins accepted per frame, order preserved; no bins lost or duplicated over 4 frames.
- mel_done_i asserted same cycle as 257th write -> one IDLE cycle, then mel_start_o; mel_done_i pulsed while IDLE -> no state change.
- rst_n dropped mid-frame (after 100 bins) and again while MEL BUSY -> all outputs 0 asynchronously; after release, a fresh 257-bin frame produces one start, and reads return the new values.
- Golden-model run: bench MEL model reads all 257 bins after each start (one address per cycle) and compares against the stored frame for 8 frames -> zero mismatches.
